pwm_mode_ctrl: RTL and testbench
================================

PWM_MODE_CTRL -- requirements
Module: pwm_mode_ctrl

Interface
REQ-001 Parameter WAKE_CYCLES, default 16: oscillator-stabilise delay in clk_i cycles, range 1..65535.
REQ-002 Parameter PRESCALE_RESET, default 8'h1E: prescale value loaded at reset.
REQ-003 clk_i  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 sleep_req_i  input  1  level; 1 requests sleep (MODE1.SLEEP).
REQ-006 prescale_wr_i  input  1  single-cycle prescale write strobe.
REQ-007 prescale_data_i  input  8  prescale write data.
REQ-008 restart_i  input  1  single-cycle restart strobe (MODE1.RESTART write-1).
REQ-009 counter_i  input  12  live count from the prescaled counter.
REQ-010 prescale_value_o  output  8  registered; drives the prescaled counter's prescale input.
REQ-011 counter_run_o  output  1  registered; enables the prescaled counter.
REQ-012 sleep_o  output  1  registered; 1 in SLEEP state.
REQ-013 restart_ro  output  1  registered; restart-pending status.
REQ-014 wr_rejected_o  output  1  registered; one-cycle pulse when a prescale write is refused.

Function
REQ-015 States: SLEEP, WAKING, RUN, DRAIN, HOLD.
REQ-016 SLEEP: sleep_req_i=0 -> WAKING with wake timer loaded to WAKE_CYCLES.
REQ-017 WAKING: timer decrements each cycle; at 0 -> HOLD if restart_ro=1, else RUN; sleep_req_i=1 -> SLEEP immediately, timer discarded.
REQ-018 RUN: counter_run_o=1; sleep_req_i=1 -> DRAIN, or SLEEP directly if counter_i==12'hFFF that cycle.
REQ-019 DRAIN: counter_run_o stays 1 until counter_i==12'hFFF, then -> SLEEP and restart_ro set to 1; sleep_req_i=0 in DRAIN -> RUN, restart_ro unchanged.
REQ-020 HOLD: counter_run_o=0; restart_i=1 -> RUN and restart_ro cleared same edge; sleep_req_i=1 -> SLEEP (takes priority over restart_i).
REQ-021 restart_i outside HOLD has no effect.
REQ-022 Prescale write accepted only in SLEEP: prescale_value_o <= max(prescale_data_i, 8'h03) next edge.
REQ-023 Prescale write in any other state: value unchanged, wr_rejected_o=1 for exactly the next cycle.
REQ-024 counter_run_o=1 only in RUN and DRAIN; sleep_o=1 only in SLEEP.
REQ-025 All outputs change one cycle after the causing input edge; no combinational input-to-output paths.

Reset
REQ-026 rst_ni low, any state: state=SLEEP, prescale_value_o=PRESCALE_RESET, counter_run_o=0, sleep_o=1, restart_ro=0, wr_rejected_o=0, wake timer=0.
REQ-027 Reset asserted mid-DRAIN or mid-WAKING aborts immediately; restart_ro is not set.

Configuration
REQ-028 Macro PWM_MODE_EXTCLK_EN defined: adds input extclk_i (1 bit); extclk_i=1 makes SLEEP -> RUN/HOLD directly, skipping WAKING.
REQ-029 Macro undefined: no extclk_i port; WAKING is always traversed.

Structure
REQ-030 Package pwm_mode_pkg holds the state enum, PRESCALE_MIN=8'h03 and the 12-bit COUNTER_TOP=12'hFFF constant.
REQ-031 The wake timer is a sub-module, pwm_wake_timer (load, decrement, zero flag).

Verification
REQ-032 Reset, write 8'h02 in SLEEP -> prescale_value_o=8'h03, wr_rejected_o stays 0.
REQ-033 Drop sleep_req_i, WAKE_CYCLES=16 -> counter_run_o rises 17 cycles later; prescale write in RUN -> wr_rejected_o single pulse, value unchanged.
REQ-034 Raise sleep_req_i at counter_i=12'h800 -> counter_run_o held 1 until counter_i=12'hFFF, then sleep_o=1, restart_ro=1.
REQ-035 Wake with restart_ro=1 -> HOLD with counter_run_o=0; restart_i pulse -> RUN, restart_ro=0; restart_i and sleep_req_i together -> SLEEP.
REQ-036 Drop rst_ni mid-WAKING and mid-DRAIN -> all outputs at reset values within the same cycle, restart_ro=0.
REQ-037 With PWM_MODE_EXTCLK_EN and extclk_i=1 -> counter_run_o rises one cycle after sleep_req_i falls.

Source files
------------

// File: rtl/pwm_mode_ctrl_pkg.sv
// Shared types and constants for the PWM mode controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_mode_pkg;

  typedef enum logic [2:0] {
    ST_SLEEP  = 3'd0,
    ST_WAKING = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HOLD   = 3'd4
  } pwm_state_e;

  localparam logic [7:0]  PRESCALE_MIN = 8'h03;
  localparam logic [11:0] COUNTER_TOP  = 12'hFFF;
  localparam int unsigned WAKE_TIMER_W = 16;

  // Prescale values below the minimum would stall the PWM period; clamp up.
  function automatic logic [7:0] prescale_clamp(input logic [7:0] val);
    return (val < PRESCALE_MIN) ? PRESCALE_MIN : val;
  endfunction

endpackage

// File: rtl/pwm_mode_ctrl_if.sv
// Control/status bundle between the register front-end and the mode controller.
// Latency: n/a (wires only).
// Backpressure: none; strobes are single-cycle and always accepted or flagged.
interface pwm_mode_ctrl_if;
  logic        sleep_req_i;
  logic        prescale_wr_i;
  logic [7:0]  prescale_data_i;
  logic        restart_i;
  logic [11:0] counter_i;
  logic [7:0]  prescale_value_o;
  logic        counter_run_o;
  logic        sleep_o;
  logic        restart_ro;
  logic        wr_rejected_o;

  // Register front-end side: drives requests, observes status.
  modport master (
    output sleep_req_i, prescale_wr_i, prescale_data_i, restart_i, counter_i,
    input  prescale_value_o, counter_run_o, sleep_o, restart_ro, wr_rejected_o
  );

  // Controller side.
  modport slave (
    input  sleep_req_i, prescale_wr_i, prescale_data_i, restart_i, counter_i,
    output prescale_value_o, counter_run_o, sleep_o, restart_ro, wr_rejected_o
  );
endinterface

// File: rtl/pwm_mode_ctrl_wake_timer.sv
// Oscillator-stabilise down-counter: load, decrement, flag when the count reaches zero.
// Latency: zero_nxt_o is combinational from the count register (no input path).
// Backpressure: none; any cycle without load or decrement clears the count.
module pwm_wake_timer
  import pwm_mode_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_i,
  input  logic                    dec_i,
  input  logic [WAKE_TIMER_W-1:0] load_val_i,
  output logic                    zero_nxt_o
);

  logic [WAKE_TIMER_W-1:0] cnt_q;

  // Count hits zero on this cycle's decrement (or is already there).
  assign zero_nxt_o = (cnt_q <= WAKE_TIMER_W'(1));

  // Load on entry, decrement while waking, discard otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i) begin
      if (cnt_q != '0) cnt_q <= cnt_q - WAKE_TIMER_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/pwm_mode_ctrl.sv
// PWM mode FSM (SLEEP/WAKING/RUN/DRAIN/HOLD) gating the prescaled counter; optional PWM_MODE_EXTCLK_EN adds extclk_i to skip WAKING.
// Latency: every output registered, one cycle after the causing input edge.
// Backpressure: none; prescale writes outside SLEEP are dropped and flagged for one cycle.
module pwm_mode_ctrl
  import pwm_mode_pkg::*;
#(
  parameter int unsigned WAKE_CYCLES    = 16,
  parameter logic [7:0]  PRESCALE_RESET = 8'h1E
) (
  input  logic             clk_i,
  input  logic             rst_ni,
`ifdef PWM_MODE_EXTCLK_EN
  input  logic             extclk_i,
`endif
  pwm_mode_ctrl_if.slave   bus
);

  pwm_state_e state_q;
  logic [7:0] prescale_q;
  logic       run_q;
  logic       sleep_q;
  logic       restart_q;
  logic       wr_rejected_q;
  logic       ext_wake;
  logic       timer_load;
  logic       timer_dec;
  logic       timer_zero;

`ifdef PWM_MODE_EXTCLK_EN
  assign ext_wake = extclk_i;
`else
  assign ext_wake = 1'b0;
`endif

  // Timer is armed on leaving SLEEP and only counts while still waking.
  assign timer_load = (state_q == ST_SLEEP) && !bus.sleep_req_i && !ext_wake;
  assign timer_dec  = (state_q == ST_WAKING) && !bus.sleep_req_i;

  pwm_wake_timer u_wake_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (timer_load),
    .dec_i      (timer_dec),
    .load_val_i (WAKE_TIMER_W'(WAKE_CYCLES)),
    .zero_nxt_o (timer_zero)
  );

  // Mode FSM; outputs are set alongside each transition so they stay registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_SLEEP;
      prescale_q    <= PRESCALE_RESET;
      run_q         <= 1'b0;
      sleep_q       <= 1'b1;
      restart_q     <= 1'b0;
      wr_rejected_q <= 1'b0;
    end else begin
      wr_rejected_q <= bus.prescale_wr_i && (state_q != ST_SLEEP);
      if (bus.prescale_wr_i && (state_q == ST_SLEEP)) begin
        prescale_q <= prescale_clamp(bus.prescale_data_i);
      end

      case (state_q)
        ST_SLEEP: begin
          if (!bus.sleep_req_i) begin
            sleep_q <= 1'b0;
            if (!ext_wake) begin
              state_q <= ST_WAKING;
            end else if (restart_q) begin
              state_q <= ST_HOLD;
            end else begin
              state_q <= ST_RUN;
              run_q   <= 1'b1;
            end
          end
        end
        ST_WAKING: begin
          if (bus.sleep_req_i) begin
            state_q <= ST_SLEEP;
            sleep_q <= 1'b1;
          end else if (timer_zero) begin
            if (restart_q) begin
              state_q <= ST_HOLD;
            end else begin
              state_q <= ST_RUN;
              run_q   <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (bus.sleep_req_i) begin
            if (bus.counter_i == COUNTER_TOP) begin
              state_q <= ST_SLEEP;
              run_q   <= 1'b0;
              sleep_q <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!bus.sleep_req_i) begin
            state_q <= ST_RUN;
          end else if (bus.counter_i == COUNTER_TOP) begin
            state_q   <= ST_SLEEP;
            run_q     <= 1'b0;
            sleep_q   <= 1'b1;
            restart_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (bus.sleep_req_i) begin
            state_q <= ST_SLEEP;
            sleep_q <= 1'b1;
          end else if (bus.restart_i) begin
            state_q   <= ST_RUN;
            run_q     <= 1'b1;
            restart_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_SLEEP;
          run_q   <= 1'b0;
          sleep_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.prescale_value_o = prescale_q;
  assign bus.counter_run_o    = run_q;
  assign bus.sleep_o          = sleep_q;
  assign bus.restart_ro       = restart_q;
  assign bus.wr_rejected_o    = wr_rejected_q;

endmodule

// File: tb/tb_pwm_mode_ctrl.sv
// Directed bench for pwm_mode_ctrl with hand-computed expectations.
// Latency: outputs sampled on the falling edge after each capturing rising edge.
// Backpressure: n/a.
module tb_pwm_mode_ctrl;

  logic clk;
  logic rst_n;
  logic extclk;
  int   n_tests;
  int   n_fail;

  pwm_mode_ctrl_if bus();

  pwm_mode_ctrl #(
    .WAKE_CYCLES    (16),
    .PRESCALE_RESET (8'h1E)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
`ifdef PWM_MODE_EXTCLK_EN
    .extclk_i (extclk),
`endif
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    extclk  = 1'b0;
    rst_n   = 1'b0;
    bus.sleep_req_i     = 1'b1;
    bus.prescale_wr_i   = 1'b0;
    bus.prescale_data_i = 8'h00;
    bus.restart_i       = 1'b0;
    bus.counter_i       = 12'h000;
    tick(2);

    // Reset state
    chk("rst_prescale", 32'(bus.prescale_value_o), 32'h1E);
    chk("rst_run",      32'(bus.counter_run_o), 0);
    chk("rst_sleep",    32'(bus.sleep_o), 1);
    chk("rst_restart",  32'(bus.restart_ro), 0);
    chk("rst_rej",      32'(bus.wr_rejected_o), 0);
    rst_n = 1'b1;
    tick(1);

    // Prescale writes in SLEEP: below minimum clamps, above passes through
    bus.prescale_wr_i = 1'b1; bus.prescale_data_i = 8'h02;
    tick(1);
    bus.prescale_wr_i = 1'b0;
    chk("clamp_02", 32'(bus.prescale_value_o), 32'h03);
    chk("clamp_rej", 32'(bus.wr_rejected_o), 0);
    bus.prescale_wr_i = 1'b1; bus.prescale_data_i = 8'h04;
    tick(1);
    bus.prescale_wr_i = 1'b0;
    chk("write_04", 32'(bus.prescale_value_o), 32'h04);

    // Wake: 16 cycles of WAKING, run rises on the 17th edge
    bus.sleep_req_i = 1'b0;
    tick(1);
    chk("waking_sleep", 32'(bus.sleep_o), 0);
    chk("waking_run0", 32'(bus.counter_run_o), 0);
    tick(15);
    chk("waking_run16", 32'(bus.counter_run_o), 0);
    tick(1);
    chk("run_rise17", 32'(bus.counter_run_o), 1);

    // restart_i in RUN is ignored
    bus.restart_i = 1'b1;
    tick(1);
    bus.restart_i = 1'b0;
    chk("run_restart_ign", 32'(bus.restart_ro), 0);
    chk("run_still", 32'(bus.counter_run_o), 1);

    // Prescale write in RUN is rejected with a one-cycle pulse
    bus.prescale_wr_i = 1'b1; bus.prescale_data_i = 8'h55;
    tick(1);
    bus.prescale_wr_i = 1'b0;
    chk("run_rej_pulse", 32'(bus.wr_rejected_o), 1);
    chk("run_rej_value", 32'(bus.prescale_value_o), 32'h04);
    tick(1);
    chk("run_rej_end", 32'(bus.wr_rejected_o), 0);

    // Drain from mid-count, brief un-request back to RUN, then finish at top
    bus.counter_i = 12'h800; bus.sleep_req_i = 1'b1;
    tick(1);
    chk("drain_run", 32'(bus.counter_run_o), 1);
    chk("drain_sleep", 32'(bus.sleep_o), 0);
    bus.sleep_req_i = 1'b0;
    tick(1);
    chk("drain_back_restart", 32'(bus.restart_ro), 0);
    bus.sleep_req_i = 1'b1;
    tick(1);
    bus.counter_i = 12'h900;
    tick(2);
    chk("drain_hold_run", 32'(bus.counter_run_o), 1);
    bus.counter_i = 12'hFFF;
    tick(1);
    bus.counter_i = 12'h000;
    chk("drain_done_sleep", 32'(bus.sleep_o), 1);
    chk("drain_done_run", 32'(bus.counter_run_o), 0);
    chk("drain_done_restart", 32'(bus.restart_ro), 1);

    // Wake with restart pending -> HOLD; restart_i during WAKING ignored
    bus.sleep_req_i = 1'b0;
    tick(5);
    bus.restart_i = 1'b1;
    tick(1);
    bus.restart_i = 1'b0;
    tick(11);
    chk("hold_run", 32'(bus.counter_run_o), 0);
    chk("hold_sleep", 32'(bus.sleep_o), 0);
    chk("hold_restart", 32'(bus.restart_ro), 1);
    bus.restart_i = 1'b1;
    tick(1);
    bus.restart_i = 1'b0;
    chk("hold_to_run", 32'(bus.counter_run_o), 1);
    chk("hold_restart_clr", 32'(bus.restart_ro), 0);

    // Re-arm restart, wake into HOLD, then sleep and restart together
    bus.sleep_req_i = 1'b1; bus.counter_i = 12'h100;
    tick(1);
    bus.counter_i = 12'hFFF;
    tick(1);
    bus.counter_i = 12'h000;
    chk("rearm_restart", 32'(bus.restart_ro), 1);
    bus.sleep_req_i = 1'b0;
    tick(17);
    chk("hold2_run", 32'(bus.counter_run_o), 0);
    bus.restart_i = 1'b1; bus.sleep_req_i = 1'b1;
    tick(1);
    bus.restart_i = 1'b0;
    chk("prio_sleep", 32'(bus.sleep_o), 1);
    chk("prio_restart", 32'(bus.restart_ro), 1);
    chk("prio_run", 32'(bus.counter_run_o), 0);

    // Reset mid-WAKING
    bus.sleep_req_i = 1'b0;
    tick(5);
    chk("pre_rst_waking", 32'(bus.sleep_o), 0);
    rst_n = 1'b0;
    #1;
    chk("rstw_sleep", 32'(bus.sleep_o), 1);
    chk("rstw_restart", 32'(bus.restart_ro), 0);
    chk("rstw_prescale", 32'(bus.prescale_value_o), 32'h1E);
    chk("rstw_run", 32'(bus.counter_run_o), 0);
    bus.sleep_req_i = 1'b1;
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Reset mid-DRAIN
    bus.sleep_req_i = 1'b0;
    tick(17);
    chk("pre_drain_run", 32'(bus.counter_run_o), 1);
    bus.sleep_req_i = 1'b1; bus.counter_i = 12'h800;
    tick(2);
    chk("mid_drain_run", 32'(bus.counter_run_o), 1);
    rst_n = 1'b0;
    #1;
    chk("rstd_run", 32'(bus.counter_run_o), 0);
    chk("rstd_sleep", 32'(bus.sleep_o), 1);
    chk("rstd_restart", 32'(bus.restart_ro), 0);
    chk("rstd_rej", 32'(bus.wr_rejected_o), 0);
    bus.counter_i = 12'h000;
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // RUN straight to SLEEP when the counter is already at top
    bus.sleep_req_i = 1'b0;
    tick(17);
    bus.sleep_req_i = 1'b1; bus.counter_i = 12'hFFF;
    tick(1);
    bus.counter_i = 12'h000;
    chk("direct_sleep", 32'(bus.sleep_o), 1);
    chk("direct_run", 32'(bus.counter_run_o), 0);

`ifdef PWM_MODE_EXTCLK_EN
    // External clock skips WAKING entirely
    extclk = 1'b1;
    bus.sleep_req_i = 1'b0;
    tick(1);
    chk("extclk_run", 32'(bus.counter_run_o), 1);
    extclk = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
